// File: rtl/bitonic_pkg.sv
// rtl/bitonic_pkg.sv - shared types and helpers for the bitonic stream sequencer
//
// Contents:
//   state_e   : sequencer state (FILL, SETTLE, DRAIN)
//   cnt_w     : counter width for a frame of num words ($clog2(num)+1)
//   pad_value : pad word that sorts to the tail for the given direction
//               (low w bits valid, w <= 64)
package bitonic_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  function automatic int cnt_w(input int num);
    return $clog2(num) + 1;
  endfunction

  // Ascending sorts put all-ones last; descending sorts put all-zeros last.
  function automatic logic [63:0] pad_value(input logic dir, input int w);
    logic [63:0] ones;
    ones = '1;
    return dir ? 64'd0 : (ones >> (64 - w));
  endfunction

endpackage

// File: rtl/bitonic_serializer.sv
// rtl/bitonic_serializer.sv - output buffer and word-per-cycle replay of a sorted frame
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : capture net_out_i into the buffer and start replay
//   net_out_i    : sorted NUM*W vector from the network
//   frame_len_i  : number of words to replay for this frame
//   out_ready_i  : downstream accepts
//   out_valid_o  : downstream word valid (registered)
//   out_data_o   : buffer word rd_cnt
//   out_last_o   : final word of the frame
//   done_o       : the out_last word transfers this cycle
module bitonic_serializer
  import bitonic_pkg::*;
#(
  parameter int NUM   = 16,
  parameter int W     = 16,
  parameter int CNT_W = cnt_w(NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [NUM*W-1:0]   net_out_i,
  input  logic [CNT_W-1:0]   frame_len_i,
  input  logic               out_ready_i,
  output logic               out_valid_o,
  output logic [W-1:0]       out_data_o,
  output logic               out_last_o,
  output logic               done_o
);

  logic [W-1:0]     buf_q [NUM];
  logic [CNT_W-1:0] rd_cnt_q;
  logic             valid_q;

  assign out_valid_o = valid_q;
  // rd_cnt never reaches NUM while valid, so the low bits are a full index.
  assign out_data_o  = buf_q[rd_cnt_q[CNT_W-2:0]];
  assign out_last_o  = valid_q && (rd_cnt_q == (frame_len_i - CNT_W'(1)));
  assign done_o      = valid_q & out_ready_i & out_last_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM; k++) buf_q[k] <= '0;
      rd_cnt_q <= '0;
      valid_q  <= 1'b0;
    end else if (load_i) begin
      for (int k = 0; k < NUM; k++) buf_q[k] <= net_out_i[k*W +: W];
      rd_cnt_q <= '0;
      valid_q  <= 1'b1;
    end else if (valid_q && out_ready_i) begin
      if (out_last_o) begin
        valid_q  <= 1'b0;
        rd_cnt_q <= '0;
      end else begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bitonic_stream_sequencer.sv
// rtl/bitonic_stream_sequencer.sv - stream front/back end for a combinational bitonic network
//
// Collects NUM words into slot registers driving net_in, waits one SETTLE
// cycle, then replays the registered net_out one word per cycle.
// Optional feature macro: BITONIC_PAD_EN (in_flush closes a partial frame,
// padding the remaining slots so pads sort to the tail and are not emitted).
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     : upstream word stream
//   in_flush                      : close partial frame (BITONIC_PAD_EN only)
//   net_in, net_dir               : vector and direction to the network
//   net_out                       : sorted vector from the network
//   out_valid/out_ready/out_data  : downstream word stream
//   out_last                      : final word of frame
module bitonic_stream_sequencer
  import bitonic_pkg::*;
#(
  parameter int NUM = 16,
  parameter int W   = 16,
  parameter bit DIR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_flush,
  output logic [NUM*W-1:0] net_in,
  output logic             net_dir,
  input  logic [NUM*W-1:0] net_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last
);

  localparam int               CNT_W    = cnt_w(NUM);
  localparam int               IDX_W    = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(NUM);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM - 1);

  state_e           state_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [W-1:0]     slot_q [NUM];
  logic [CNT_W-1:0] frame_len;
  logic             xfer_in;
  logic             ser_done;

  assign in_ready = (state_q == FILL);
  assign xfer_in  = in_valid & in_ready;
  assign net_dir  = DIR;

  for (genvar g = 0; g < NUM; g++) begin : g_net_in
    assign net_in[g*W +: W] = slot_q[g];
  end

`ifdef BITONIC_PAD_EN
  localparam logic [63:0]  PAD_FULL = pad_value(DIR, W);
  localparam logic [W-1:0] PAD      = PAD_FULL[W-1:0];

  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] fill_n;

  // Slots occupied after this edge: a same-cycle word counts before the pad.
  assign fill_n    = wr_cnt_q + CNT_W'(xfer_in);
  assign frame_len = len_q;
`else
  logic unused_flush;

  assign unused_flush = in_flush;
  assign frame_len    = FULL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      for (int k = 0; k < NUM; k++) slot_q[k] <= '0;
`ifdef BITONIC_PAD_EN
      len_q    <= FULL;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (xfer_in) slot_q[wr_cnt_q[IDX_W-1:0]] <= in_data;
`ifdef BITONIC_PAD_EN
          if (fill_n == FULL) begin
            wr_cnt_q <= fill_n;
            len_q    <= FULL;
            state_q  <= SETTLE;
          end else if (in_flush && (fill_n != '0)) begin
            for (int k = 0; k < NUM; k++) begin
              if (CNT_W'(k) >= fill_n) slot_q[k] <= PAD;
            end
            wr_cnt_q <= fill_n;
            len_q    <= fill_n;
            state_q  <= SETTLE;
          end else begin
            wr_cnt_q <= fill_n;
          end
`else
          if (xfer_in) begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            if (wr_cnt_q == LAST_IDX) state_q <= SETTLE;
          end
`endif
        end
        SETTLE: state_q <= DRAIN;
        DRAIN: begin
          if (ser_done) begin
            wr_cnt_q <= '0;
            state_q  <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  bitonic_serializer #(
    .NUM   (NUM),
    .W     (W),
    .CNT_W (CNT_W)
  ) u_serializer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (state_q == SETTLE),
    .net_out_i   (net_out),
    .frame_len_i (frame_len),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .done_o      (ser_done)
  );

endmodule

// File: tb/tb_bitonic_stream_sequencer.sv
// tb/tb_bitonic_stream_sequencer.sv - self-checking bench for bitonic_stream_sequencer
module tb_bitonic_stream_sequencer;

  localparam int NUM = 16;
  localparam int W   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           sel;
  logic           in_valid, in_flush, out_ready;
  logic [W-1:0]   in_data;

  logic             ir0, ir1, ov0, ov1, ol0, ol1, nd0, nd1;
  logic [W-1:0]     od0, od1;
  logic [NUM*W-1:0] ni0, ni1, no0, no1;

  logic           o_in_ready, o_out_valid, o_out_last;
  logic [W-1:0]   o_out_data;

  assign o_in_ready  = sel ? ir1 : ir0;
  assign o_out_valid = sel ? ov1 : ov0;
  assign o_out_last  = sel ? ol1 : ol0;
  assign o_out_data  = sel ? od1 : od0;

  // Behavioural stand-in for the sorting network.
  function automatic logic [NUM*W-1:0] sort_vec(input logic [NUM*W-1:0] v, input bit d);
    logic [W-1:0]     a[$];
    logic [NUM*W-1:0] r;
    for (int i = 0; i < NUM; i++) a.push_back(v[i*W +: W]);
    if (d) a.rsort();
    else   a.sort();
    for (int i = 0; i < NUM; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  assign no0 = sort_vec(ni0, 1'b0);
  assign no1 = sort_vec(ni1, 1'b1);

  bitonic_stream_sequencer #(.NUM(NUM), .W(W), .DIR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel), .in_ready(ir0), .in_data(in_data),
    .in_flush(in_flush & ~sel),
    .net_in(ni0), .net_dir(nd0), .net_out(no0),
    .out_valid(ov0), .out_ready(out_ready & ~sel), .out_data(od0), .out_last(ol0)
  );

  bitonic_stream_sequencer #(.NUM(NUM), .W(W), .DIR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel), .in_ready(ir1), .in_data(in_data),
    .in_flush(in_flush & sel),
    .net_in(ni1), .net_dir(nd1), .net_out(no1),
    .out_valid(ov1), .out_ready(out_ready & sel), .out_data(od1), .out_last(ol1)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fw [NUM];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] first_w, last_w;

  typedef struct {
    bit           dir;
    int           kind;      // 0: 16..1, 1: DIR=1 pattern, 2: random, 3: all equal
    int           rdy_pct;
    bit           chk_ends;
    logic [W-1:0] exp_first;
    logic [W-1:0] exp_last;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic feed(input int n);
    int  i   = 0;
    int  cyc = 0;
    bit  go;
    while (i < n && cyc < 400) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = fw[i];
      go       = o_in_ready;
      @(posedge clk);
      if (go) i++;
      cyc++;
    end
    if (i < n) chk("feed_timeout", i, n);
  endtask

  task automatic drain(input int len, input int pct);
    int           k   = 0;
    int           cyc = 0;
    bit           go, stalled;
    logic [W-1:0] prev;
    stalled = 1'b0;
    prev    = '0;
    while (k < len && cyc < 2000) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < pct);
      if (cyc == 0) chk("latency_valid", o_out_valid, 1);
      chk("in_ready_drain", o_in_ready, 0);
      if (o_out_valid) begin
        if (stalled) chk("stall_hold", o_out_data, prev);
        chk("data", o_out_data, exp_q[k]);
        chk("last", o_out_last, (k == len - 1));
        if (k == 0)       first_w = o_out_data;
        if (k == len - 1) last_w  = o_out_data;
      end
      prev    = o_out_data;
      stalled = o_out_valid && !out_ready;
      go      = o_out_valid && out_ready;
      @(posedge clk);
      if (go) k++;
      cyc++;
    end
    if (k < len) chk("drain_timeout", k, len);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_last", o_in_ready, 1);
    chk("valid_after_last", o_out_valid, 0);
  endtask

  // Reference: the frame is exactly the words fed, sorted in the direction.
  task automatic run_frame(input bit d, input int n, input bit flush, input int pct);
    sel = d;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(fw[i]);
    if (d) exp_q.rsort();
    else   exp_q.sort();
    feed(n);
    if (flush) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_flush = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_flush = 1'b0;
    chk("settle_valid", o_out_valid, 0);
    chk("settle_ready", o_in_ready, 0);
    drain(n, pct);
  endtask

  initial begin
    tbl[0] = '{1'b0, 0, 100, 1'b1, 16'd1,    16'd16};
    tbl[1] = '{1'b0, 0, 50,  1'b1, 16'd1,    16'd16};
    tbl[2] = '{1'b0, 2, 50,  1'b0, 16'd0,    16'd0};
    tbl[3] = '{1'b0, 2, 100, 1'b0, 16'd0,    16'd0};
    tbl[4] = '{1'b1, 1, 100, 1'b1, 16'hFFFF, 16'h0001};
    tbl[5] = '{1'b1, 2, 50,  1'b0, 16'd0,    16'd0};
    tbl[6] = '{1'b0, 3, 70,  1'b1, 16'h1234, 16'h1234};

    sel = 1'b0; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b0; in_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", ir0, 1);
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_last", ol0, 0);
    chk("rst_out_data", od0, 0);
    chk("rst_net_in", (ni0 == '0), 1);
    chk("net_dir0", nd0, 0);
    chk("net_dir1", nd1, 1);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < NUM; i++) begin
        case (tbl[t].kind)
          0:       fw[i] = W'(NUM - i);
          1:       fw[i] = (i == 0) ? 16'h0001 : (i == 1) ? 16'hFFFF :
                           (i == 2) ? 16'h8000 : W'(i * 256);
          2:       fw[i] = W'($urandom);
          default: fw[i] = 16'h1234;
        endcase
      end
      run_frame(tbl[t].dir, NUM, 1'b0, tbl[t].rdy_pct);
      if (tbl[t].chk_ends) begin
        chk("table_first", first_w, tbl[t].exp_first);
        chk("table_last", last_w, tbl[t].exp_last);
      end
    end

    // Reset in the middle of a frame, then a fresh frame.
    sel = 1'b0;
    for (int i = 0; i < NUM; i++) fw[i] = W'($urandom);
    feed(7);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", ov0, 0);
    chk("midrst_out_data", od0, 0);
    chk("midrst_out_last", ol0, 0);
    chk("midrst_in_ready", ir0, 1);
    chk("midrst_net_in", (ni0 == '0), 1);
    rst_n = 1'b1;
    for (int i = 0; i < NUM; i++) fw[i] = W'($urandom);
    run_frame(1'b0, NUM, 1'b0, 60);

`ifdef BITONIC_PAD_EN
    fw[0] = 16'd5; fw[1] = 16'd3; fw[2] = 16'd9;
    run_frame(1'b0, 3, 1'b1, 100);
    chk("pad_first", first_w, 16'd3);
    chk("pad_last", last_w, 16'd9);

    sel = 1'b0;
    @(negedge clk);
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    chk("idle_flush_ready", o_in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_flush_valid", o_out_valid, 0);
    end
    for (int i = 0; i < NUM; i++) fw[i] = W'($urandom);
    run_frame(1'b0, NUM, 1'b0, 100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
